// File: rtl/fpu_share_arb.sv
// Round-robin sequencer that time-shares one combinational bfloat16 FPU
// between N_REQ requesters: accept, execute for one cycle, return result.
module fpu_share_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [4*N_REQ-1:0]    req_op_i,
    input  logic [16*N_REQ-1:0]   req_in1_i,
    input  logic [16*N_REQ-1:0]   req_in2_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output logic [15:0]           rsp_data_o,
    output logic                  rsp_overflow_o,
    output logic                  rsp_err_o,
    output logic [3:0]            fpu_op_o,
    output logic [15:0]           fpu_in1_o,
    output logic [15:0]           fpu_in2_o,
    input  logic [15:0]           fpu_out_i,
    input  logic                  fpu_overflow_i,
    output logic                  busy_o,
    output logic [IDW-1:0]        grant_id_o
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] next_ptr;
    logic           found;
    logic [N_REQ-1:0] rot;
    logic [3:0]     op_sel;
    logic [15:0]    in1_sel;
    logic [15:0]    in2_sel;
    logic           rsp_done;

    function automatic logic [IDW-1:0] wrap_add(
        input logic [IDW-1:0] base,
        input int             k
    );
        logic [IDW:0] s;
        s = {1'b0, base} + (IDW+1)'(k);
        if (s >= (IDW+1)'(N_REQ)) begin
            s = s - (IDW+1)'(N_REQ);
        end
        return s[IDW-1:0];
    endfunction

    // Rotate valids so bit 0 is the requester at ptr; lowest set bit wins.
    assign rot = N_REQ'({req_valid_i, req_valid_i} >> ptr);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pick  = wrap_add(ptr, k);
            end
        end
    end

    assign next_ptr = wrap_add(pick, 1);
    assign op_sel   = 4'(req_op_i >> (4 * pick));
    assign in1_sel  = 16'(req_in1_i >> (16 * pick));
    assign in2_sel  = 16'(req_in2_i >> (16 * pick));
    assign rsp_done = |(rsp_ready_i & rsp_valid_o);

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state == IDLE && found) begin
            req_ready_o = N_REQ'(1) << pick;
        end
    end

    assign busy_o     = (state != IDLE);
    assign grant_id_o = owner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            fpu_op_o       <= '0;
            fpu_in1_o      <= '0;
            fpu_in2_o      <= '0;
            rsp_valid_o    <= '0;
            rsp_data_o     <= '0;
            rsp_overflow_o <= 1'b0;
            rsp_err_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= pick;
                        ptr       <= next_ptr;
                        fpu_in1_o <= in1_sel;
                        fpu_in2_o <= in2_sel;
                        // An illegal op never reaches the FPU.
                        fpu_op_o  <= $onehot(op_sel) ? op_sel : 4'b0000;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (|fpu_op_o) begin
                        rsp_data_o     <= fpu_out_i;
                        rsp_overflow_o <= fpu_overflow_i;
                        rsp_err_o      <= 1'b0;
                    end else begin
                        rsp_data_o     <= QNAN;
                        rsp_overflow_o <= 1'b0;
                        rsp_err_o      <= 1'b1;
                    end
                    fpu_op_o    <= '0;
                    rsp_valid_o <= N_REQ'(1) << owner;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid_o <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_arb.sv
// Bench for fpu_share_arb: transaction-level reference model, a stand-in
// bfloat16 FPU built on real arithmetic, directed cases and random traffic.
module tb_fpu_share_arb;

    localparam int N   = 4;
    localparam int IDW = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_op;
    logic [16*N-1:0] req_in1;
    logic [16*N-1:0] req_in2;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [15:0]     rsp_data;
    logic            rsp_ovf;
    logic            rsp_err;
    logic [3:0]      fpu_op;
    logic [15:0]     fpu_in1;
    logic [15:0]     fpu_in2;
    logic [15:0]     fpu_out;
    logic            fpu_ovf;
    logic            busy;
    logic [IDW-1:0]  grant_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_share_arb #(.N_REQ(N), .IDW(IDW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_in1_i      (req_in1),
        .req_in2_i      (req_in2),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .rsp_overflow_o (rsp_ovf),
        .rsp_err_o      (rsp_err),
        .fpu_op_o       (fpu_op),
        .fpu_in1_o      (fpu_in1),
        .fpu_in2_o      (fpu_in2),
        .fpu_out_i      (fpu_out),
        .fpu_overflow_i (fpu_ovf),
        .busy_o         (busy),
        .grant_id_o     (grant_id)
    );

    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:7] == 8'd0) return 0.0;
        d = {x[15], 11'(int'(x[14:7]) - 127 + 1023), x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {overflow, bf16}, truncating the mantissa.
    function automatic logic [16:0] r2bf(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (d[62:52] == 11'd0) return {1'b0, d[63], 15'd0};
        if (e >= 255) return {1'b1, d[63], 8'hFF, 7'd0};
        if (e <= 0) return {1'b0, d[63], 15'd0};
        return {1'b0, d[63], 8'(e), d[51:45]};
    endfunction

    function automatic logic [16:0] fpu_eval(
        input logic [3:0] op, input logic [15:0] a, input logic [15:0] b
    );
        real x;
        real y;
        x = bf2r(a);
        y = bf2r(b);
        case (op)
            4'b0001: return r2bf(x + y);
            4'b0010: return r2bf(x - y);
            4'b0100: return r2bf(x * y);
            4'b1000: return r2bf(x / y);
            default: return 17'h0_1234;
        endcase
    endfunction

    always_comb {fpu_ovf, fpu_out} = fpu_eval(fpu_op, fpu_in1, fpu_in2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding transaction, phase 0 idle, 1 exec, 2 resp.
    int          m_ph  = 0;
    int          m_ptr = 0;
    int          m_own = 0;
    logic [3:0]  m_op  = '0;
    logic [15:0] m_a   = '0;
    logic [15:0] m_b   = '0;
    logic [15:0] m_res = '0;
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    logic [N-1:0] acc_evt = '0;

    always @(negedge clk) begin
        int g;
        int j;
        logic [N-1:0] er;
        acc_evt = '0;
        if (!rst_n) begin
            m_ph = 0; m_ptr = 0; m_own = 0; m_op = '0;
            m_a = '0; m_b = '0; m_res = '0; m_ovf = 1'b0; m_err = 1'b0;
        end
        g = -1;
        if (rst_n && m_ph == 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        er = (g >= 0) ? N'(1) << g : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), (m_ph == 2) ? 32'(1) << m_own : 32'd0);
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("grant_id", 32'(grant_id), 32'(m_own));
        chk("fpu_op", 32'(fpu_op), (m_ph == 1 && $onehot(m_op)) ? 32'(m_op) : 32'd0);
        chk("fpu_in1", 32'(fpu_in1), 32'(m_a));
        chk("fpu_in2", 32'(fpu_in2), 32'(m_b));
        chk("rsp_data", 32'(rsp_data), 32'(m_res));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        if (rst_n) begin
            if (g >= 0) begin
                m_op  = req_op[4*g +: 4];
                m_a   = req_in1[16*g +: 16];
                m_b   = req_in2[16*g +: 16];
                m_own = g;
                m_ptr = (g + 1) % N;
                m_ph  = 1;
                acc_evt[g] = 1'b1;
            end else if (m_ph == 1) begin
                if ($onehot(m_op)) {m_ovf, m_res} = fpu_eval(m_op, m_a, m_b);
                else begin m_res = 16'h7FC0; m_ovf = 1'b0; end
                m_err = !$onehot(m_op);
                m_ph  = 2;
            end else if (m_ph == 2 && rsp_ready[m_own]) begin
                m_ph = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_valid[i]      = v;
        req_op[4*i +: 4]  = op;
        req_in1[16*i +: 16] = a;
        req_in2[16*i +: 16] = b;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Runs one request to its first RESP cycle; ends at that negedge.
    task automatic txn(input int i, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [N-1:0] rr,
                       output logic [3:0] seen);
        int n = 0;
        seen = '0;
        rsp_ready = rr;
        set_req(i, 1'b1, op, a, b);
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("txn_grant", 32'(req_ready[i]), 32'd1);
        tick();
        req_valid[i] = 1'b0;
        @(negedge clk);
        seen |= fpu_op;
        tick();
        @(negedge clk);
        seen |= fpu_op;
    endtask

    function automatic logic [3:0] rnd_op();
        int r = $urandom_range(11);
        if (r < 10) return 4'(1 << (r % 4));
        return 4'($urandom);
    endfunction

    function automatic logic [15:0] rnd_bf();
        return {1'($urandom), 8'($urandom_range(154, 100)), 7'($urandom)};
    endfunction

    task automatic rnd_drive();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !acc_evt[i]) begin
                if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                set_req(i, 1'b1, rnd_op(), rnd_bf(), rnd_bf());
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        rsp_ready = N'($urandom);
    endtask

    initial begin
        int gi[$];
        int gc[$];
        int n;
        logic [3:0] seen;
        req_valid = '0;
        req_op    = '0;
        req_in1   = '0;
        req_in2   = '0;
        rsp_ready = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // single ADD, 1.0 + 2.0
        set_req(0, 1'b1, 4'b0001, 16'h3F80, 16'h4000);
        @(negedge clk);
        chk("add_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("add_exec_op", 32'(fpu_op), 32'h1);
        chk("add_no_early_rsp", 32'(rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_data", 32'(rsp_data), 32'h4040);
        chk("add_ovf", 32'(rsp_ovf), 32'h0);
        chk("add_err", 32'(rsp_err), 32'h0);
        tick();
        rsp_ready = '1;
        tick();
        @(negedge clk);
        chk("add_idle", 32'(busy), 32'h0);
        chk("add_data_hold", 32'(rsp_data), 32'h4040);

        // round robin, all valid, MUL 2.0 * 3.0
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'b0100, 16'h4000, 16'h4040);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gi.push_back(i);
                    gc.push_back(c);
                end
            end
            if (|rsp_valid) chk("rr_data", 32'(rsp_data), 32'h40C0);
        end
        chk("rr_count", 32'(gi.size()), 32'd5);
        for (int k = 0; k < gi.size() && k < 5; k++) begin
            chk("rr_order", 32'(gi[k]), 32'(k % N));
            if (k > 0) chk("rr_gap", 32'(gc[k] - gc[k-1]), 32'd3);
        end
        tick();
        req_valid = '0;
        wait_idle(10);

        // response backpressure, DIV 3.0 / 2.0
        txn(2, 4'b1000, 16'h4040, 16'h4000, 4'b1011, seen);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'h4);
            chk("bp_data", 32'(rsp_data), 32'h3FC0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            set_req(0, 1'b1, 4'b0001, 16'h3F80, 16'h3F80);
            @(negedge clk);
        end
        tick();
        rsp_ready = '1;
        tick();
        @(negedge clk);
        chk("bp_exit_busy", 32'(busy), 32'h0);
        chk("bp_exit_valid", 32'(rsp_valid), 32'h0);
        chk("bp_exit_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_idle(10);

        // overflow, then illegal op
        txn(1, 4'b0100, 16'h7F00, 16'h7F00, '0, seen);
        chk("ovf_flag", 32'(rsp_ovf), 32'h1);
        chk("ovf_data", 32'(rsp_data), 32'h7F80);
        chk("ovf_err", 32'(rsp_err), 32'h0);
        tick();
        rsp_ready = '1;
        wait_idle(10);
        txn(3, 4'b0011, 16'h3F80, 16'h4000, '0, seen);
        chk("ill_err", 32'(rsp_err), 32'h1);
        chk("ill_data", 32'(rsp_data), 32'h7FC0);
        chk("ill_ovf", 32'(rsp_ovf), 32'h0);
        chk("ill_fpu_op", 32'(seen), 32'h0);
        tick();
        rsp_ready = '1;
        wait_idle(10);

        // reset during EXEC
        rsp_ready = '0;
        set_req(1, 1'b1, 4'b0001, 16'h3F80, 16'h3F80);
        n = 0;
        @(negedge clk);
        while (!req_ready[1] && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("rm_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("rm_in_exec", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_fpu_op", 32'(fpu_op), 32'h0);
        chk("rm_fpu_in1", 32'(fpu_in1), 32'h0);
        chk("rm_grant_id", 32'(grant_id), 32'h0);
        chk("rm_rsp_data", 32'(rsp_data), 32'h0);
        chk("rm_rsp_err", 32'(rsp_err), 32'h0);
        set_req(0, 1'b1, 4'b0010, 16'h4040, 16'h3F80);
        set_req(1, 1'b1, 4'b0001, 16'h3F80, 16'h3F80);
        chk("rm_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rm_first", 32'(req_ready), 32'h1);
        chk("rm_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        wait_idle(10);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            rnd_drive();
        end
        tick();
        req_valid = '0;
        rsp_ready = '1;
        wait_idle(20);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
